// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/sequencing controller for the 5-stage RV32 pipeline.
// Generates RAW forwarding selects, load-use bubbles, redirect flushes and a
// bus-freeze with timeout. Optional build macro HAZ_PERF_CNT_EN adds three
// saturating 32-bit event counters (perf_lu_cnt, perf_flush_cnt, perf_wait_cnt).
module pipe_hazard_ctrl #(
  parameter int unsigned BUS_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_rf_we,
  input  logic       ex_is_load,
  input  logic [4:0] mem_rd,
  input  logic       mem_rf_we,
  input  logic [4:0] wb_rd,
  input  logic       wb_rf_we,
  input  logic       ex_redirect,
  input  logic       bus_req,
  input  logic       bus_ready,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_flush,
  output logic       idex_stall,
  output logic       idex_flush,
  output logic       exmem_stall,
  output logic       memwb_flush,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       bus_err,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0] perf_lu_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_wait_cnt,
`endif
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_LU    = 2'b01,
    ST_BUS   = 2'b10,
    ST_REDIR = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
  logic             freeze;
  logic             lu_hit;

  // Operand forwarding: the younger EX/MEM result wins over MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic use_rs,
                                         input logic [4:0] m_rd, input logic m_we,
                                         input logic [4:0] w_rd, input logic w_we);
    if (rs == 5'd0 || !use_rs) return 2'b00;
    if (m_we && m_rd == rs)    return 2'b01;
    if (w_we && w_rd == rs)    return 2'b10;
    return 2'b00;
  endfunction

  // Freeze holds while the bridge is busy and the wait budget is not exhausted.
  assign freeze = bus_req && !bus_ready && (cnt_q < CNT_W'(BUS_TIMEOUT));

  // Load in EX whose destination is a live source of the ID instruction.
  assign lu_hit = ex_is_load && ex_rf_we && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

  // State, wait counter and timeout pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next state and control outputs, prioritised bus wait > redirect > load-use.
  always_comb begin
    state_d     = ST_RUN;
    cnt_d       = '0;
    bus_err_d   = 1'b0;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    memwb_flush = 1'b0;
    fwd_a_sel   = 2'b00;
    fwd_b_sel   = 2'b00;
    if (!rst_i) begin
      fwd_a_sel = fwd_sel(id_rs1, id_use_rs1, mem_rd, mem_rf_we, wb_rd, wb_rf_we);
      fwd_b_sel = fwd_sel(id_rs2, id_use_rs2, mem_rd, mem_rf_we, wb_rd, wb_rf_we);
      if (freeze) begin
        // Whole pipe holds; a bubble drains into WB so the access is not retired twice.
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_flush = 1'b1;
        cnt_d       = cnt_q + CNT_W'(1);
        // Raise the error in the cycle the counter reaches the limit and the freeze drops.
        bus_err_d   = (cnt_q == CNT_W'(BUS_TIMEOUT - 1));
        state_d     = ST_BUS;
      end else if (ex_redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        state_d    = ST_REDIR;
      end else if (lu_hit && state_q != ST_REDIR) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
        state_d    = ST_LU;
      end
    end
  end

  assign bus_err = bus_err_q;
  assign state_o = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_lu_q, perf_flush_q, perf_wait_q;

  // Saturating event counters; a load-use bubble is the only idex_flush without ifid_flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_lu_q    <= '0;
      perf_flush_q <= '0;
      perf_wait_q  <= '0;
    end else begin
      if (idex_flush && !ifid_flush && perf_lu_q != '1) perf_lu_q    <= perf_lu_q + 32'd1;
      if (ifid_flush && perf_flush_q != '1)              perf_flush_q <= perf_flush_q + 32'd1;
      if (memwb_flush && perf_wait_q != '1)              perf_wait_q  <= perf_wait_q + 32'd1;
    end
  end

  assign perf_lu_cnt    = perf_lu_q;
  assign perf_flush_cnt = perf_flush_q;
  assign perf_wait_cnt  = perf_wait_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (BUS_TIMEOUT=4).
module tb_pipe_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_rf_we, ex_is_load, mem_rf_we, wb_rf_we;
  logic       ex_redirect, bus_req, bus_ready;
  logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic       exmem_stall, memwb_flush, bus_err;
  logic [1:0] fwd_a_sel, fwd_b_sel, state_o;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_lu_cnt, perf_flush_cnt, perf_wait_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl #(.BUS_TIMEOUT(4), .CNT_W(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_rf_we(mem_rf_we), .wb_rd(wb_rd), .wb_rf_we(wb_rf_we),
    .ex_redirect(ex_redirect), .bus_req(bus_req), .bus_ready(bus_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_stall(exmem_stall),
    .memwb_flush(memwb_flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .bus_err(bus_err),
`ifdef HAZ_PERF_CNT_EN
    .perf_lu_cnt(perf_lu_cnt), .perf_flush_cnt(perf_flush_cnt), .perf_wait_cnt(perf_wait_cnt),
`endif
    .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = '0; ex_rf_we = 0; ex_is_load = 0;
    mem_rd = '0; mem_rf_we = 0; wb_rd = '0; wb_rf_we = 0;
    ex_redirect = 0; bus_req = 0; bus_ready = 0;
  endtask

  // Full-freeze signature: all four holds plus the WB bubble, no front-end flushes.
  task automatic chk_freeze(input string tag, input logic exp);
    chk({tag, "_pc"},    32'(pc_stall),    32'(exp));
    chk({tag, "_ifid"},  32'(ifid_stall),  32'(exp));
    chk({tag, "_idex"},  32'(idex_stall),  32'(exp));
    chk({tag, "_exmem"}, 32'(exmem_stall), 32'(exp));
    chk({tag, "_memwb"}, 32'(memwb_flush), 32'(exp));
  endtask

  initial begin
    clr();
    // Reset with hazard-provoking inputs: everything must read idle.
    rst_i = 1; bus_req = 1; ex_redirect = 1;
    id_rs1 = 5; id_use_rs1 = 1; mem_rd = 5; mem_rf_we = 1;
    tick();
    chk("rst_state", 32'(state_o), 32'(2'b00));
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk_freeze("rst", 1'b0);
    chk("rst_ifid_flush", 32'(ifid_flush), 32'd0);
    chk("rst_fwd_a", 32'(fwd_a_sel), 32'(2'b00));
    rst_i = 0; clr(); tick();

    // Forwarding priority and zero-register / unused-source exclusions.
    id_rs1 = 5; id_use_rs1 = 1; mem_rd = 5; mem_rf_we = 1; wb_rd = 5; wb_rf_we = 1; #1;
    chk("fwd_a_mem", 32'(fwd_a_sel), 32'(2'b01));
    mem_rf_we = 0; #1;
    chk("fwd_a_wb", 32'(fwd_a_sel), 32'(2'b10));
    id_rs1 = 0; #1;
    chk("fwd_a_x0", 32'(fwd_a_sel), 32'(2'b00));
    id_rs1 = 5; id_use_rs1 = 0; #1;
    chk("fwd_a_unused", 32'(fwd_a_sel), 32'(2'b00));
    id_rs2 = 9; id_use_rs2 = 1; wb_rd = 9; #1;
    chk("fwd_b_wb", 32'(fwd_b_sel), 32'(2'b10));
    chk("fwd_no_stall", 32'(pc_stall), 32'd0);
    clr(); tick();

    // Load-use bubble, then forwarding from MEM on the replay.
    ex_is_load = 1; ex_rf_we = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; #1;
    chk("lu_pc", 32'(pc_stall), 32'd1);
    chk("lu_ifid", 32'(ifid_stall), 32'd1);
    chk("lu_idex_flush", 32'(idex_flush), 32'd1);
    chk("lu_ifid_flush", 32'(ifid_flush), 32'd0);
    chk("lu_exmem", 32'(exmem_stall), 32'd0);
    tick();
    chk("lu_state", 32'(state_o), 32'(2'b01));
    ex_is_load = 0; ex_rf_we = 0; ex_rd = 0; mem_rd = 7; mem_rf_we = 1; #1;
    chk("lu_replay_pc", 32'(pc_stall), 32'd0);
    chk("lu_replay_fwd_b", 32'(fwd_b_sel), 32'(2'b01));
    tick();
    chk("lu_back_run", 32'(state_o), 32'(2'b00));
    clr();

    // Back-to-back load-use while in LU_STALL stalls again.
    ex_is_load = 1; ex_rf_we = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1; tick();
    ex_rd = 4; id_rs1 = 4; #1;
    chk("lu_b2b_pc", 32'(pc_stall), 32'd1);
    tick();
    chk("lu_b2b_state", 32'(state_o), 32'(2'b01));
    clr(); tick();

    // Redirect beats load-use; load-use suppressed during REDIRECT.
    ex_is_load = 1; ex_rf_we = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; ex_redirect = 1; #1;
    chk("rd_ifid_flush", 32'(ifid_flush), 32'd1);
    chk("rd_idex_flush", 32'(idex_flush), 32'd1);
    chk("rd_pc", 32'(pc_stall), 32'd0);
    chk("rd_ifid_stall", 32'(ifid_stall), 32'd0);
    tick();
    chk("rd_state", 32'(state_o), 32'(2'b11));
    ex_redirect = 0; #1;
    chk("rd_lu_suppr_pc", 32'(pc_stall), 32'd0);
    chk("rd_lu_suppr_flush", 32'(idex_flush), 32'd0);
    tick();
    chk("rd_back_run", 32'(state_o), 32'(2'b00));
    clr(); tick();

    // Bus wait of 3 cycles with a redirect held behind the freeze.
    bus_req = 1; ex_redirect = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_freeze("bw", 1'b1);
      chk("bw_ifid_flush", 32'(ifid_flush), 32'd0);
      chk("bw_idex_flush", 32'(idex_flush), 32'd0);
      tick();
      chk("bw_state", 32'(state_o), 32'(2'b10));
      chk("bw_err", 32'(bus_err), 32'd0);
    end
    bus_ready = 1; #1;
    chk_freeze("bw_rel", 1'b0);
    chk("bw_rel_redirect", 32'(ifid_flush), 32'd1);
    tick();
    chk("bw_rel_state", 32'(state_o), 32'(2'b11));
    chk("bw_rel_err", 32'(bus_err), 32'd0);
    clr(); tick();
    chk("bw_run", 32'(state_o), 32'(2'b00));

    // Timeout: 4 frozen cycles, forced release with a one-cycle bus_err.
    bus_req = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_freeze("to", 1'b1);
      chk("to_err_low", 32'(bus_err), 32'd0);
      tick();
    end
    chk("to_err", 32'(bus_err), 32'd1);
    chk_freeze("to_rel", 1'b0);
    chk("to_state", 32'(state_o), 32'(2'b10));
    bus_req = 0; tick();
    chk("to_err_drop", 32'(bus_err), 32'd0);
    chk("to_run", 32'(state_o), 32'(2'b00));

    // Reset mid-freeze, then a fresh full-length freeze proves the counter cleared.
    bus_req = 1; tick(); tick();
    chk("rmf_state", 32'(state_o), 32'(2'b10));
    rst_i = 1; #1;
    chk_freeze("rmf_inrst", 1'b0);
    tick();
    chk("rmf_state_rst", 32'(state_o), 32'(2'b00));
    chk("rmf_err", 32'(bus_err), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("rmf_perf_lu", perf_lu_cnt, 32'd0);
    chk("rmf_perf_flush", perf_flush_cnt, 32'd0);
    chk("rmf_perf_wait", perf_wait_cnt, 32'd0);
`endif
    rst_i = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_freeze("rmf_refreeze", 1'b1);
      tick();
    end
    chk("rmf_to_err", 32'(bus_err), 32'd1);
    chk("rmf_to_pc", 32'(pc_stall), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("perf_wait_after", perf_wait_cnt, 32'd4);
`endif
    clr(); tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32 core (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Detects RAW hazards and produces operand-forwarding selects.
- Inserts load-use bubbles and flushes wrong-path instructions on EX-resolved redirects.
- Freezes the pipe while a slow bridge access is pending, with a timeout counter.
- All stage registers and the PC take their stall/flush controls from this block.

Parameters:
BUS_TIMEOUT, 16, max consecutive freeze cycles waiting for bus_ready before forced release (>=1)
CNT_W, 5, width of the bus-wait counter; must satisfy 2^CNT_W > BUS_TIMEOUT

Ports:
clk_i  in  1  core clock (cpu_clk)
rst_i  in  1  synchronous reset, active-high
id_rs1  in  5  ID-stage source register 1
id_rs2  in  5  ID-stage source register 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  EX-stage destination register
ex_rf_we  in  1  EX instruction writes RF
ex_is_load  in  1  EX instruction is a load
mem_rd  in  5  MEM-stage destination register
mem_rf_we  in  1  MEM instruction writes RF
wb_rd  in  5  WB-stage destination register
wb_rf_we  in  1  WB instruction writes RF
ex_redirect  in  1  EX resolved a taken branch or jump
bus_req  in  1  MEM stage performs a bridge access this cycle
bus_ready  in  1  bridge completes the access this cycle
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID
ifid_flush  out  1  load NOP into IF/ID
idex_stall  out  1  hold ID/EX
idex_flush  out  1  load NOP into ID/EX
exmem_stall  out  1  hold EX/MEM
memwb_flush  out  1  load NOP into MEM/WB
fwd_a_sel  out  2  00 RF, 01 EX/MEM result, 10 MEM/WB writeback value
fwd_b_sel  out  2  same encoding for rs2
bus_err  out  1  one-cycle pulse on bus timeout
state_o  out  2  current FSM state (debug)

Behaviour:
- FSM states: RUN=00, LU_STALL=01, BUS_WAIT=10, REDIRECT=11. Registered, updated on the rising edge of clk_i.
- Reset (rst_i=1 at the edge): state=RUN, wait counter=0, bus_err=0. While rst_i=1, all stall/flush outputs read 0 and fwd selects read 00.
- Forwarding (combinational):
  - rsX==0 or use bit low -> 00.
  - Otherwise, mem_rf_we && mem_rd==rsX -> 01.
  - Otherwise, wb_rf_we && wb_rd==rsX -> 10.
  - Otherwise 00. EX/MEM has priority over MEM/WB.
- Event priority in any cycle: bus wait > redirect > load-use.
- Bus wait:
  - Condition: bus_req && !bus_ready while counter < BUS_TIMEOUT.
  - Response: pc_stall, ifid_stall, idex_stall and exmem_stall all =1; memwb_flush=1; no flushes of IF/ID or ID/EX.
  - Next state BUS_WAIT; counter increments each freeze cycle.
  - When bus_ready rises, the freeze releases in that same cycle; counter clears; next state is RUN.
  - If counter reaches BUS_TIMEOUT: bus_err pulses for 1 cycle, the freeze releases (access treated as complete), counter clears.
  - A pending ex_redirect is held in place by the freeze and takes effect in the first unfrozen cycle.
- Redirect:
  - Condition: ex_redirect=1 and not frozen.
  - Response: ifid_flush=1, idex_flush=1, no stalls. Next state REDIRECT for exactly 1 cycle, then RUN.
  - In REDIRECT, load-use detection is suppressed because ID holds a flushed NOP.
- Load-use:
  - Condition: ex_is_load && ex_rf_we && ex_rd!=0 && ex_rd matches a used ID source. Not frozen, no redirect.
  - Response: pc_stall=1, ifid_stall=1, idex_flush=1. Next state LU_STALL.
  - In LU_STALL the same ID instruction is re-evaluated. The load is now in MEM and is covered by forwarding 01 on the next cycle (10 once in WB). Return to RUN.
  - A back-to-back load-use in LU_STALL, against a new EX load, stalls again.
- Combinational outputs depend only on the current inputs and state; no added latency.
- Combinations not listed above produce 0 on the stall/flush outputs.

Optional Feature:
HAZ_PERF_CNT_EN.
- Defined: adds outputs perf_lu_cnt, perf_flush_cnt, perf_wait_cnt (32 bits each). They count load-use bubbles, redirect events and bus-freeze cycles respectively. All are cleared by rst_i and saturate at 0xFFFFFFFF.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Forwarding: id_rs1=5, mem_rd=5 mem_rf_we=1, wb_rd=5 wb_rf_we=1 -> fwd_a_sel=01. Then mem_rf_we=0 -> 10. Then id_rs1=0 -> 00.
- Load-use: ex_is_load=1 ex_rd=7, id_rs2=7 id_use_rs2=1 -> pc_stall=ifid_stall=idex_flush=1 for one cycle, state_o=01. Next cycle with load in MEM (mem_rd=7) -> no stall, fwd_b_sel=01.
- Redirect versus load-use in the same cycle: ex_redirect=1 plus a load-use match -> ifid_flush=idex_flush=1, pc_stall=0; state_o=11 then 00.
- Bus wait: bus_req=1, bus_ready low for 3 cycles then high -> all four stalls and memwb_flush=1 for 3 cycles, released in cycle 4, bus_err never asserts.
- Timeout: BUS_TIMEOUT=4, bus_ready held 0 -> freeze for 4 cycles, bus_err=1 on cycle 5 for exactly one cycle, stalls drop, counter=0.
- Reset mid-freeze: rst_i=1 during BUS_WAIT -> next edge state_o=00, all outputs 0, perf counters 0 (if enabled).
